// File: rtl/watch_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | watch_set_ctrl: button-driven time-setting controller; edits a shadow |
// | copy of the live time and commits it with a one-cycle set_time.      |
// | Optional edit timeout: WATCH_SET_TIMEOUT_EN                          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module watch_set_ctrl #(
   parameter int TIMEOUT_S = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk1sec,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic [11:0] cur_year,
   input  logic [7:0]  cur_month,
   input  logic [7:0]  cur_day,
   input  logic [7:0]  cur_hour,
   input  logic [7:0]  cur_minute,
   input  logic [7:0]  cur_second,
   output logic [51:0] bin_time,
   output logic        set_time,
   output logic        editing,
   output logic [2:0]  edit_field,
   output logic        blink
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EDIT   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [2:0] c_FLD_YEAR   = 3'd0;
   localparam logic [2:0] c_FLD_MONTH  = 3'd1;
   localparam logic [2:0] c_FLD_DAY    = 3'd2;
   localparam logic [2:0] c_FLD_HOUR   = 3'd3;
   localparam logic [2:0] c_FLD_MINUTE = 3'd4;
   localparam logic [2:0] c_FLD_SECOND = 3'd5;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_field, w_field_nxt;
   logic [11:0] r_year, w_year_nxt;
   logic [7:0]  r_month, r_day, r_hour, r_minute, r_second;
   logic [7:0]  w_month_nxt, w_day_nxt, w_hour_nxt, w_minute_nxt, w_second_nxt;
   logic [7:0]  w_cap_month, w_cap_mday, w_mday, w_new_mday;
   logic        r_set, r_editing, r_blink;

`ifdef WATCH_SET_TIMEOUT_EN
   localparam logic [7:0] c_TMO = 8'(TIMEOUT_S);
   logic [7:0]  r_tmo, w_tmo_nxt;
   logic        w_any_btn;
`else
   localparam int c_unused_timeout = TIMEOUT_S;
`endif

   function automatic logic [7:0] f_max_day(input logic [7:0] mon, input logic [11:0] yr);
      logic leap;
      leap = (((yr % 12'd4) == 12'd0) && ((yr % 12'd100) != 12'd0)) || ((yr % 12'd400) == 12'd0);
      case (mon)
         8'd2:                    f_max_day = leap ? 8'd29 : 8'd28;
         8'd4, 8'd6, 8'd9, 8'd11: f_max_day = 8'd30;
         default:                 f_max_day = 8'd31;
      endcase
   endfunction

   always_comb begin
      w_state_nxt  = r_state;
      w_field_nxt  = r_field;
      w_year_nxt   = r_year;
      w_month_nxt  = r_month;
      w_day_nxt    = r_day;
      w_hour_nxt   = r_hour;
      w_minute_nxt = r_minute;
      w_second_nxt = r_second;
      w_cap_month  = (cur_month == 8'd0 || cur_month > 8'd12) ? 8'd1 : cur_month;
      w_cap_mday   = f_max_day(w_cap_month, cur_year);
      w_mday       = f_max_day(r_month, r_year);
      case (r_state)
         S_IDLE: begin
            if (btn_mode) begin
               w_state_nxt  = S_EDIT;
               w_field_nxt  = c_FLD_YEAR;
               w_year_nxt   = cur_year;
               w_month_nxt  = w_cap_month;
               w_day_nxt    = (cur_day == 8'd0 || cur_day > w_cap_mday) ? 8'd1 : cur_day;
               w_hour_nxt   = (cur_hour > 8'd23) ? 8'd0 : cur_hour;
               w_minute_nxt = (cur_minute > 8'd59) ? 8'd0 : cur_minute;
               w_second_nxt = (cur_second > 8'd59) ? 8'd0 : cur_second;
            end
         end
         S_EDIT: begin
            if (btn_mode) begin
               w_state_nxt = S_IDLE;
            end else if (btn_next) begin
               if (r_field == c_FLD_SECOND) w_state_nxt = S_COMMIT;
               else                         w_field_nxt = r_field + 3'd1;
            end else if (btn_up || btn_down) begin
               // btn_up selects the direction; it outranks a coincident btn_down
               case (r_field)
                  c_FLD_YEAR:   w_year_nxt = btn_up ? ((r_year >= 12'd4095) ? 12'd1 : r_year + 12'd1)
                                                    : ((r_year <= 12'd1) ? 12'd4095 : r_year - 12'd1);
                  c_FLD_MONTH:  w_month_nxt = btn_up ? ((r_month >= 8'd12) ? 8'd1 : r_month + 8'd1)
                                                     : ((r_month <= 8'd1) ? 8'd12 : r_month - 8'd1);
                  c_FLD_DAY:    w_day_nxt = btn_up ? ((r_day >= w_mday) ? 8'd1 : r_day + 8'd1)
                                                   : ((r_day <= 8'd1) ? w_mday : r_day - 8'd1);
                  c_FLD_HOUR:   w_hour_nxt = btn_up ? ((r_hour >= 8'd23) ? 8'd0 : r_hour + 8'd1)
                                                    : ((r_hour == 8'd0) ? 8'd23 : r_hour - 8'd1);
                  c_FLD_MINUTE: w_minute_nxt = btn_up ? ((r_minute >= 8'd59) ? 8'd0 : r_minute + 8'd1)
                                                      : ((r_minute == 8'd0) ? 8'd59 : r_minute - 8'd1);
                  c_FLD_SECOND: w_second_nxt = btn_up ? ((r_second >= 8'd59) ? 8'd0 : r_second + 8'd1)
                                                      : ((r_second == 8'd0) ? 8'd59 : r_second - 8'd1);
                  default: ;
               endcase
            end
         end
         S_COMMIT: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
      // A year/month change can leave the day past the new month's end
      w_new_mday = f_max_day(w_month_nxt, w_year_nxt);
      if (r_state == S_EDIT && w_day_nxt > w_new_mday) w_day_nxt = w_new_mday;
`ifdef WATCH_SET_TIMEOUT_EN
      w_any_btn = btn_mode | btn_next | btn_up | btn_down;
      w_tmo_nxt = 8'd0;
      if (r_state == S_EDIT && !w_any_btn && clk1sec) begin
         if (r_tmo + 8'd1 >= c_TMO) w_state_nxt = S_IDLE;
         else                       w_tmo_nxt   = r_tmo + 8'd1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_field   <= c_FLD_YEAR;
         r_set     <= 1'b0;
         r_editing <= 1'b0;
         r_blink   <= 1'b0;
         r_year    <= 12'd2021;
         r_month   <= 8'd12;
         r_day     <= 8'd31;
         r_hour    <= 8'd23;
         r_minute  <= 8'd59;
         r_second  <= 8'd50;
`ifdef WATCH_SET_TIMEOUT_EN
         r_tmo     <= 8'd0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_field   <= (w_state_nxt == S_IDLE) ? c_FLD_YEAR : w_field_nxt;
         r_set     <= (w_state_nxt == S_COMMIT);
         r_editing <= (w_state_nxt != S_IDLE);
         if (w_state_nxt == S_IDLE)               r_blink <= 1'b0;
         else if (r_state == S_EDIT && clk1sec)   r_blink <= ~r_blink;
         r_year    <= w_year_nxt;
         r_month   <= w_month_nxt;
         r_day     <= w_day_nxt;
         r_hour    <= w_hour_nxt;
         r_minute  <= w_minute_nxt;
         r_second  <= w_second_nxt;
`ifdef WATCH_SET_TIMEOUT_EN
         r_tmo     <= w_tmo_nxt;
`endif
      end
   end

   assign bin_time   = {r_year, r_month, r_day, r_hour, r_minute, r_second};
   assign set_time   = r_set;
   assign editing    = r_editing;
   assign edit_field = r_field;
   assign blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_watch_set_ctrl.sv
`default_nettype none
// Testbench for watch_set_ctrl: table-driven edit/commit vectors plus hand-written corner sequences.
module tb_watch_set_ctrl;

   logic        clk = 1'b0;
   logic        rst, clk1sec, btn_mode, btn_next, btn_up, btn_down;
   logic [11:0] cur_year;
   logic [7:0]  cur_month, cur_day, cur_hour, cur_minute, cur_second;
   logic [51:0] bin_time;
   logic        set_time, editing, blink;
   logic [2:0]  edit_field;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   int pulses0;

   typedef struct {
      logic        mode, next, up, down, tick;
      logic        ed;
      logic [2:0]  fld;
      logic        st, bl;
      logic [51:0] bin;
   } vec_t;

   vec_t vecs[10];

   watch_set_ctrl #(.TIMEOUT_S(3)) dut (
      .clk(clk), .rst(rst), .clk1sec(clk1sec),
      .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
      .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
      .bin_time(bin_time), .set_time(set_time), .editing(editing),
      .edit_field(edit_field), .blink(blink)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (set_time) pulses <= pulses + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [51:0] pk(input logic [11:0] y, input logic [7:0] mo, d, h, mi, s);
      return {y, mo, d, h, mi, s};
   endfunction

   function automatic vec_t mk(input logic m, n, u, d, t, ed, input logic [2:0] f,
                               input logic st, bl, input logic [51:0] bin);
      vec_t v;
      v.mode = m; v.next = n; v.up = u; v.down = d; v.tick = t;
      v.ed = ed; v.fld = f; v.st = st; v.bl = bl; v.bin = bin;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic m, n, u, d, t);
      btn_mode = m; btn_next = n; btn_up = u; btn_down = d; clk1sec = t;
      @(posedge clk);
      #1;
      btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0; clk1sec = 1'b0;
   endtask

   task automatic set_live(input logic [11:0] y, input logic [7:0] mo, d, h, mi, s);
      cur_year = y; cur_month = mo; cur_day = d; cur_hour = h; cur_minute = mi; cur_second = s;
   endtask

   // Live Mar 31; edit month down, step to the last field, commit.
   task automatic load_table(input logic [11:0] y, input logic [7:0] fd);
      logic [51:0] a, b;
      a = pk(y, 8'd3, 8'd31, 8'd10, 8'd20, 8'd30);
      b = pk(y, 8'd2, fd,    8'd10, 8'd20, 8'd30);
      set_live(y, 8'd3, 8'd31, 8'd10, 8'd20, 8'd30);
      vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, a);
      vecs[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, a);
      vecs[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, b);
      vecs[3] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, b);
      vecs[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, b);
      vecs[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, b);
      vecs[6] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, b);
      vecs[7] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, b);
      vecs[8] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, b);
      vecs[9] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, b);
   endtask

   task automatic run_table(input int y);
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].mode, vecs[i].next, vecs[i].up, vecs[i].down, vecs[i].tick);
         chk($sformatf("y%0d_v%0d_editing", y, i), 64'(editing), 64'(vecs[i].ed));
         chk($sformatf("y%0d_v%0d_field", y, i), 64'(edit_field), 64'(vecs[i].fld));
         chk($sformatf("y%0d_v%0d_set_time", y, i), 64'(set_time), 64'(vecs[i].st));
         chk($sformatf("y%0d_v%0d_blink", y, i), 64'(blink), 64'(vecs[i].bl));
         chk($sformatf("y%0d_v%0d_bin_time", y, i), 64'(bin_time), 64'(vecs[i].bin));
      end
   endtask

   initial begin
      rst = 1'b1; clk1sec = 1'b0;
      btn_mode = 1'b0; btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      set_live(12'd2000, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_bin_time", 64'(bin_time), 64'(pk(12'd2021, 8'd12, 8'd31, 8'd23, 8'd59, 8'd50)));
      chk("reset_set_time", 64'(set_time), 64'd0);
      chk("reset_editing", 64'(editing), 64'd0);
      chk("reset_field", 64'(edit_field), 64'd0);
      chk("reset_blink", 64'(blink), 64'd0);
      rst = 1'b0;

      load_table(12'd2024, 8'd29); run_table(2024);
      load_table(12'd2023, 8'd28); run_table(2023);
      load_table(12'd1900, 8'd28); run_table(1900);
      load_table(12'd2000, 8'd29); run_table(2000);
      chk("commit_pulse_count", 64'(pulses), 64'd4);

      // Hour/minute/year/month wraps, shadow frozen while live time runs
      set_live(12'd1, 8'd1, 8'd15, 8'd23, 8'd59, 8'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("field_hour", 64'(edit_field), 64'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("hour_up_wrap", 64'(bin_time), 64'(pk(12'd1, 8'd1, 8'd15, 8'd0, 8'd59, 8'd0)));
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("hour_down_wrap", 64'(bin_time), 64'(pk(12'd1, 8'd1, 8'd15, 8'd23, 8'd59, 8'd0)));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("minute_up_wrap", 64'(bin_time), 64'(pk(12'd1, 8'd1, 8'd15, 8'd23, 8'd0, 8'd0)));
      cur_second = 8'd5;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("no_resample", 64'(bin_time), 64'(pk(12'd1, 8'd1, 8'd15, 8'd23, 8'd0, 8'd0)));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cancel_editing", 64'(editing), 64'd0);
      chk("cancel_retains", 64'(bin_time), 64'(pk(12'd1, 8'd1, 8'd15, 8'd23, 8'd0, 8'd0)));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("year_down_wrap", 64'(bin_time), 64'(pk(12'd4095, 8'd1, 8'd15, 8'd23, 8'd59, 8'd5)));
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("month_down_wrap", 64'(bin_time), 64'(pk(12'd4095, 8'd12, 8'd15, 8'd23, 8'd59, 8'd5)));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Cancel paths never pulse set_time; mode outranks next/up
      pulses0 = pulses;
      set_live(12'd2024, 8'd3, 8'd31, 8'd10, 8'd20, 8'd30);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cancel2_editing", 64'(editing), 64'd0);
      chk("cancel2_bin", 64'(bin_time), 64'(pk(12'd2025, 8'd3, 8'd31, 8'd10, 8'd20, 8'd30)));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("prio_editing", 64'(editing), 64'd0);
      chk("prio_field", 64'(edit_field), 64'd0);
      chk("prio_bin", 64'(bin_time), 64'(pk(12'd2024, 8'd3, 8'd31, 8'd10, 8'd20, 8'd30)));
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("cancel_no_pulse", 64'(pulses), 64'(pulses0));

      // Out-of-range live values are normalised on capture
      set_live(12'd2023, 8'd0, 8'd40, 8'd30, 8'd70, 8'd99);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("norm_zero_month", 64'(bin_time), 64'(pk(12'd2023, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0)));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      set_live(12'd2023, 8'd4, 8'd31, 8'd24, 8'd60, 8'd60);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("norm_apr31", 64'(bin_time), 64'(pk(12'd2023, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0)));
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Inactivity: abandon with the timeout, otherwise stay in edit
      pulses0 = pulses;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("tmo_restart_editing", 64'(editing), 64'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef WATCH_SET_TIMEOUT_EN
      chk("tmo_expired_editing", 64'(editing), 64'd0);
`else
      repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("no_tmo_editing", 64'(editing), 64'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
      chk("tmo_no_pulse", 64'(pulses), 64'(pulses0));

      // Reset mid-edit returns to the reset state without a pulse
      set_live(12'd2030, 8'd6, 8'd15, 8'd8, 8'd9, 8'd10);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      pulses0 = pulses;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_editing", 64'(editing), 64'd0);
      chk("rst_mid_field", 64'(edit_field), 64'd0);
      chk("rst_mid_bin", 64'(bin_time), 64'(pk(12'd2021, 8'd12, 8'd31, 8'd23, 8'd59, 8'd50)));
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_no_pulse", 64'(pulses), 64'(pulses0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
